// File: rtl/toi2s_pkg.sv
// Shared toI2S types and defaults: amp_seq state encoding, amp init table and timing constants.
package toi2s_pkg;

    typedef enum logic [3:0] {
        AMP_OFF       = 4'd0,
        AMP_PWRUP     = 4'd1,
        AMP_CFG_ISSUE = 4'd2,
        AMP_CFG_WAIT  = 4'd3,
        AMP_MUTED     = 4'd4,
        AMP_UNMUTE    = 4'd5,
        AMP_PLAY      = 4'd6,
        AMP_MUTE      = 4'd7,
        AMP_FAULT     = 4'd8
    } amp_seq_state_e;

    typedef struct packed {
        logic [7:0] regaddr;
        logic [7:0] data;
    } amp_init_entry_t;

    localparam int         AMP_SEQ_T_PWRUP   = 4096;
    localparam int         AMP_SEQ_T_RAMP    = 1024;
    localparam logic [6:0] AMP_SEQ_DEV_ADDR  = 7'h2C;
    localparam int         AMP_SEQ_N_INIT    = 4;
    localparam int         AMP_SEQ_MAX_INIT  = 16;
    localparam int         AMP_SEQ_TIMER_W   = 16;
    localparam int         AMP_SEQ_MAX_RETRY = 2;

    // Only the first N_INIT entries are written; the rest pad the table to its maximum size.
    localparam amp_init_entry_t AMP_INIT_TABLE [AMP_SEQ_MAX_INIT] = '{
        '{8'h01, 8'h80}, '{8'h02, 8'h10}, '{8'h03, 8'h0C}, '{8'h04, 8'h3F},
        '{8'h05, 8'h00}, '{8'h06, 8'h00}, '{8'h07, 8'h00}, '{8'h08, 8'h00},
        '{8'h09, 8'h00}, '{8'h0A, 8'h00}, '{8'h0B, 8'h00}, '{8'h0C, 8'h00},
        '{8'h0D, 8'h00}, '{8'h0E, 8'h00}, '{8'h0F, 8'h00}, '{8'h10, 8'h00}
    };

endpackage

// File: rtl/amp_seq_timer.sv
// Loadable 16-bit down-counter with zero flag; a load of N-1 gives an N-cycle wait.
module amp_seq_timer
    import toi2s_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_i,
    input  logic [AMP_SEQ_TIMER_W-1:0] load_val_i,
    output logic                       zero_o
);

    logic [AMP_SEQ_TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/amp_seq.sv
// amp_seq: amplifier power/mute sequencer (power-up, I2C init writes, unmute/mute, shutdown).
// Build option AMP_SEQ_RETRY_EN: a NACKed init write is reissued up to twice before faulting.
module amp_seq
    import toi2s_pkg::*;
#(
    parameter int         T_PWRUP      = AMP_SEQ_T_PWRUP,
    parameter int         T_RAMP       = AMP_SEQ_T_RAMP,
    parameter logic [6:0] AMP_DEV_ADDR = AMP_SEQ_DEV_ADDR,
    parameter int         N_INIT       = AMP_SEQ_N_INIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mute_req,
    input  logic       audio_ok,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [6:0] cmd_dev,
    output logic [7:0] cmd_reg,
    output logic [7:0] cmd_data,
    input  logic       cmd_done,
    input  logic       cmd_err,
    output logic       amp_nenable,
    output logic       amp_mute,
    output logic [3:0] state_mon,
    output logic       fault
);

    localparam int IDX_W = (N_INIT > 1) ? $clog2(N_INIT) : 1;

    amp_seq_state_e       state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 nen_q, nen_d, mute_q, mute_d, valid_q, valid_d, fault_q, fault_d;
    logic [6:0]           dev_q, dev_d;
    logic [7:0]           reg_q, reg_d, data_q, data_d;
    logic                 tmr_load, tmr_zero, play_ok;
    logic [AMP_SEQ_TIMER_W-1:0] tmr_val;
    amp_init_entry_t      init_ent;
`ifdef AMP_SEQ_RETRY_EN
    logic [1:0]           retry_q, retry_d;
`endif

    amp_seq_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nen_d    = nen_q;
        mute_d   = mute_q;
        valid_d  = valid_q;
        fault_d  = fault_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        play_ok  = enable && !mute_req && audio_ok;
`ifdef AMP_SEQ_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            AMP_OFF: if (enable) begin
                state_d  = AMP_PWRUP;
                nen_d    = 1'b0;
                fault_d  = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = AMP_SEQ_TIMER_W'(T_PWRUP - 1);
`ifdef AMP_SEQ_RETRY_EN
                retry_d  = '0;
`endif
            end
            AMP_PWRUP: begin
                if (!enable) begin
                    state_d = AMP_OFF;
                end else if (tmr_zero) begin
                    state_d = AMP_CFG_ISSUE;
                    idx_d   = '0;
                end
            end
            // An issued command is always carried to completion, even once enable drops.
            AMP_CFG_ISSUE: if (valid_q && cmd_ready) begin
                state_d = AMP_CFG_WAIT;
                valid_d = 1'b0;
            end
            AMP_CFG_WAIT: if (cmd_done) begin
                if (!enable) begin
                    state_d = AMP_OFF;
                end else if (cmd_err) begin
`ifdef AMP_SEQ_RETRY_EN
                    if (retry_q != 2'(AMP_SEQ_MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = AMP_CFG_ISSUE;
                    end else begin
                        state_d = AMP_FAULT;
                    end
`else
                    state_d = AMP_FAULT;
`endif
                end else if (idx_q == IDX_W'(N_INIT - 1)) begin
                    state_d = AMP_MUTED;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = AMP_CFG_ISSUE;
`ifdef AMP_SEQ_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            AMP_MUTED: begin
                if (!enable) begin
                    state_d = AMP_OFF;
                end else if (play_ok) begin
                    state_d  = AMP_UNMUTE;
                    tmr_load = 1'b1;
                    tmr_val  = AMP_SEQ_TIMER_W'(T_RAMP - 1);
                end
            end
            AMP_UNMUTE: begin
                if (!play_ok) begin
                    state_d = AMP_MUTED;
                end else if (tmr_zero) begin
                    state_d = AMP_PLAY;
                    mute_d  = 1'b0;
                end
            end
            AMP_PLAY: if (!play_ok) begin
                state_d  = AMP_MUTE;
                mute_d   = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = AMP_SEQ_TIMER_W'(T_RAMP - 1);
            end
            AMP_MUTE: if (tmr_zero) begin
                state_d = enable ? AMP_MUTED : AMP_OFF;
            end
            AMP_FAULT: if (!enable) begin
                state_d = AMP_OFF;
            end
            default: state_d = AMP_OFF;
        endcase

        init_ent = AMP_INIT_TABLE[4'(idx_d)];
        if (state_d == AMP_CFG_ISSUE && state_q != AMP_CFG_ISSUE) begin
            valid_d = 1'b1;
            dev_d   = AMP_DEV_ADDR;
            reg_d   = init_ent.regaddr;
            data_d  = init_ent.data;
        end
        if (state_d == AMP_OFF || state_d == AMP_FAULT) begin
            nen_d  = 1'b1;
            mute_d = 1'b1;
        end
        if (state_d == AMP_FAULT) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= AMP_OFF;
            idx_q   <= '0;
            nen_q   <= 1'b1;
            mute_q  <= 1'b1;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
`ifdef AMP_SEQ_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nen_q   <= nen_d;
            mute_q  <= mute_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
`ifdef AMP_SEQ_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign cmd_valid   = valid_q;
    assign cmd_dev     = dev_q;
    assign cmd_reg     = reg_q;
    assign cmd_data    = data_q;
    assign amp_nenable = nen_q;
    assign amp_mute    = mute_q;
    assign state_mon   = state_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_amp_seq.sv
// Self-checking bench for amp_seq: directed power-up/backpressure/NACK/reset sequences,
// a vector table for unmute/mute/shutdown, and a randomized phase against a reference model.
module tb_amp_seq;

    localparam int T_PWRUP   = 16;
    localparam int T_RAMP    = 8;
    localparam int N_INIT    = 4;
    localparam int DONE_DLY  = 3;
    localparam int STALL_LEN = 10;

    localparam int S_OFF = 0, S_PWRUP = 1, S_ISSUE = 2, S_WAIT = 3, S_MUTED = 4;
    localparam int S_UNMUTE = 5, S_PLAY = 6, S_MUTE = 7, S_FAULT = 8;

    logic       clk = 1'b0;
    logic       reset, enable, mute_req, audio_ok, cmd_ready, cmd_done, cmd_err;
    logic       cmd_valid, amp_nenable, amp_mute, fault;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg, cmd_data;
    logic [3:0] state_mon;

    always #5 clk = ~clk;

    amp_seq #(
        .T_PWRUP      (T_PWRUP),
        .T_RAMP       (T_RAMP),
        .AMP_DEV_ADDR (7'h2C),
        .N_INIT       (N_INIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mute_req    (mute_req),
        .audio_ok    (audio_ok),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dev     (cmd_dev),
        .cmd_reg     (cmd_reg),
        .cmd_data    (cmd_data),
        .cmd_done    (cmd_done),
        .cmd_err     (cmd_err),
        .amp_nenable (amp_nenable),
        .amp_mute    (amp_mute),
        .state_mon   (state_mon),
        .fault       (fault)
    );

    // Expected init writes, in order.
    logic [7:0] tab_reg [N_INIT] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] tab_dat [N_INIT] = '{8'h80, 8'h10, 8'h0C, 8'h3F};

    int n_chk = 0;
    int n_err = 0;

    // I2C master stand-in
    int         done_cnt, n_acc, stall_idx, stall_left;
    logic       err_next;
    bit         err_q [$];
    bit         rand_mode, model_chk;
    logic [6:0] log_dev [$];
    logic [15:0] log_cmd [$];

    // reference model
    int m_st, m_tmr, m_idx, m_retry;
    bit m_fault;

    typedef struct {
        logic       en;
        logic       mr;
        logic       ok;
        int         cyc;
        logic [3:0] st;
        logic       mute;
        logic       nen;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tz, ok;
        if (reset) begin
            m_st = S_OFF; m_tmr = 0; m_idx = 0; m_fault = 0; m_retry = 0;
            return;
        end
        tz = (m_tmr == 0);
        if (m_tmr > 0) m_tmr--;
        ok = enable && !mute_req && audio_ok;
        case (m_st)
            S_OFF: if (enable) begin
                m_st = S_PWRUP; m_tmr = T_PWRUP - 1; m_fault = 0; m_retry = 0;
            end
            S_PWRUP: if (!enable) m_st = S_OFF;
                     else if (tz) begin m_st = S_ISSUE; m_idx = 0; end
            S_ISSUE: if (cmd_ready) m_st = S_WAIT;
            S_WAIT: if (cmd_done) begin
                if (!enable) m_st = S_OFF;
                else if (cmd_err) begin
`ifdef AMP_SEQ_RETRY_EN
                    if (m_retry < 2) begin m_retry++; m_st = S_ISSUE; end
                    else begin m_st = S_FAULT; m_fault = 1; end
`else
                    m_st = S_FAULT; m_fault = 1;
`endif
                end else if (m_idx == N_INIT - 1) m_st = S_MUTED;
                else begin m_idx++; m_retry = 0; m_st = S_ISSUE; end
            end
            S_MUTED: if (!enable) m_st = S_OFF;
                     else if (ok) begin m_st = S_UNMUTE; m_tmr = T_RAMP - 1; end
            S_UNMUTE: if (!ok) m_st = S_MUTED;
                      else if (tz) m_st = S_PLAY;
            S_PLAY: if (!ok) begin m_st = S_MUTE; m_tmr = T_RAMP - 1; end
            S_MUTE: if (tz) m_st = enable ? S_MUTED : S_OFF;
            S_FAULT: if (!enable) m_st = S_OFF;
            default: m_st = S_OFF;
        endcase
    endtask

    task automatic model_cmp();
        chk("model_state", state_mon, m_st);
        chk("model_nenable", amp_nenable, (m_st == S_OFF || m_st == S_FAULT));
        chk("model_mute", amp_mute, (m_st != S_PLAY));
        chk("model_valid", cmd_valid, (m_st == S_ISSUE));
        chk("model_fault", fault, m_fault);
        if (m_st == S_ISSUE) begin
            chk("model_cmd_dev", cmd_dev, 7'h2C);
            chk("model_cmd", {cmd_reg, cmd_data}, {tab_reg[m_idx], tab_dat[m_idx]});
        end
    endtask

    // One clock: inputs set before the call are sampled at the edge, outputs are looked at 1 unit later.
    task automatic tick();
        bit acc;
        acc = cmd_valid && cmd_ready && !reset;
        if (acc) begin
            log_dev.push_back(cmd_dev);
            log_cmd.push_back({cmd_reg, cmd_data});
        end
        model_step();
        @(posedge clk);
        #1;
        if (model_chk) model_cmp();
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
        if (reset) begin
            done_cnt = 0;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                cmd_done = 1'b1;
                cmd_err  = err_next;
            end
        end
        if (acc) begin
            n_acc++;
            if (rand_mode) begin
                done_cnt = $urandom_range(1, 5);
                err_next = ($urandom_range(0, 7) == 0);
            end else begin
                done_cnt = DONE_DLY;
                err_next = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
            end
        end
        cmd_ready = 1'b1;
        if (rand_mode) begin
            cmd_ready = ($urandom_range(0, 2) != 0);
        end else if (n_acc == stall_idx && stall_left > 0 && (cmd_valid || stall_left < STALL_LEN)) begin
            chk("bp_valid_held", cmd_valid, 1'b1);
            chk("bp_cmd_stable", {cmd_reg, cmd_data}, {tab_reg[2], tab_dat[2]});
            cmd_ready = 1'b0;
            stall_left--;
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int max, input string name);
        int k;
        k = 0;
        while (state_mon !== s && k < max) begin
            tick();
            k++;
        end
        chk(name, state_mon, s);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state_mon, 4'd0);
        chk({tag, "_nenable"}, amp_nenable, 1'b1);
        chk({tag, "_mute"}, amp_mute, 1'b1);
        chk({tag, "_valid"}, cmd_valid, 1'b0);
        chk({tag, "_dev"}, cmd_dev, 7'h00);
        chk({tag, "_reg"}, cmd_reg, 8'h00);
        chk({tag, "_data"}, cmd_data, 8'h00);
        chk({tag, "_fault"}, fault, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // en, mute_req, audio_ok, cycles, state, mute, nenable  (starting in MUTED)
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1,          4'd5, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, T_RAMP - 1, 4'd5, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1,          4'd6, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1,          4'd7, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, T_RAMP - 1, 4'd7, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1,          4'd4, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1,          4'd5, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1,          4'd4, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, T_RAMP + 1, 4'd6, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1,          4'd7, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, T_RAMP - 1, 4'd7, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1,          4'd0, 1'b1, 1'b1};

        reset = 1'b1; enable = 1'b0; mute_req = 1'b0; audio_ok = 1'b1;
        cmd_ready = 1'b1; cmd_done = 1'b0; cmd_err = 1'b0;
        done_cnt = 0; n_acc = 0; stall_idx = -1; stall_left = 0; err_next = 1'b0;
        rand_mode = 1'b0; model_chk = 1'b0;
        m_st = S_OFF; m_tmr = 0; m_idx = 0; m_fault = 0; m_retry = 0;

        tick(); tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();

        // power-up with backpressure on entry 2
        n_acc = 0; stall_idx = 2; stall_left = STALL_LEN;
        enable = 1'b1;
        tick();
        chk("pu_nenable", amp_nenable, 1'b0);
        chk("pu_state", state_mon, 4'd1);
        k = 0;
        while (!cmd_valid && k < 100) begin tick(); k++; end
        chk("pu_first_cmd_delay", k, T_PWRUP);
        wait_state(4'd4, 400, "pu_reach_muted");
        chk("pu_n_writes", log_cmd.size(), N_INIT);
        for (int i = 0; i < log_cmd.size() && i < N_INIT; i++) begin
            chk($sformatf("pu_dev%0d", i), log_dev[i], 7'h2C);
            chk($sformatf("pu_cmd%0d", i), log_cmd[i], {tab_reg[i], tab_dat[i]});
        end
        chk("pu_mute", amp_mute, 1'b1);
        chk("pu_fault", fault, 1'b0);
        chk("pu_nenable_on", amp_nenable, 1'b0);
        chk("bp_stall_consumed", stall_left, 0);
        stall_idx = -1;

        // unmute / mute / shutdown vectors
        for (int v = 0; v < 12; v++) begin
            enable = vecs[v].en; mute_req = vecs[v].mr; audio_ok = vecs[v].ok;
            for (int c = 0; c < vecs[v].cyc; c++) tick();
            chk($sformatf("vec%0d_state", v), state_mon, vecs[v].st);
            chk($sformatf("vec%0d_mute", v), amp_mute, vecs[v].mute);
            chk($sformatf("vec%0d_nenable", v), amp_nenable, vecs[v].nen);
        end

        // NACK on entry 1
        log_dev.delete(); log_cmd.delete(); err_q.delete();
        mute_req = 1'b0; audio_ok = 1'b1;
`ifdef AMP_SEQ_RETRY_EN
        err_q.push_back(1'b0); err_q.push_back(1'b1); err_q.push_back(1'b1);
        enable = 1'b1;
        wait_state(4'd4, 400, "nack_retry_muted");
        chk("nack_retry_fault", fault, 1'b0);
        chk("nack_retry_writes", log_cmd.size(), N_INIT + 2);
        if (log_cmd.size() > 3) begin
            chk("nack_retry_same1", log_cmd[2], {tab_reg[1], tab_dat[1]});
            chk("nack_retry_same2", log_cmd[3], {tab_reg[1], tab_dat[1]});
        end
        enable = 1'b0;
        tick();
        chk("nack_retry_off", state_mon, 4'd0);
`else
        err_q.push_back(1'b0); err_q.push_back(1'b1);
        enable = 1'b1;
        wait_state(4'd8, 400, "nack_fault_state");
        chk("nack_fault_flag", fault, 1'b1);
        chk("nack_nenable", amp_nenable, 1'b1);
        chk("nack_mute", amp_mute, 1'b1);
        chk("nack_writes", log_cmd.size(), 2);
        tick(); tick();
        chk("nack_fault_stays", state_mon, 4'd8);
        enable = 1'b0;
        tick();
        chk("nack_off", state_mon, 4'd0);
        chk("nack_fault_sticky", fault, 1'b1);
        enable = 1'b1;
        tick();
        chk("nack_repwr_state", state_mon, 4'd1);
        chk("nack_fault_cleared", fault, 1'b0);
        enable = 1'b0;
        tick();
`endif
        err_q.delete();

        // randomized phase against the reference model
        rand_mode = 1'b1; model_chk = 1'b1;
        enable = 1'b1; mute_req = 1'b0; audio_ok = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) mute_req = ~mute_req;
            if ($urandom_range(0, 29) == 0) audio_ok = ~audio_ok;
            tick();
        end
        rand_mode = 1'b0; model_chk = 1'b0;

        // reset in the middle of CFG_WAIT
        reset = 1'b1; tick(); reset = 1'b0;
        enable = 1'b1; mute_req = 1'b0; audio_ok = 1'b1;
        wait_state(4'd3, 200, "rstw_reach_wait");
        chk("rstw_valid_low_in_wait", cmd_valid, 1'b0);
        reset = 1'b1;
        tick();
        chk_reset_vals("rstw");
        reset = 1'b0; enable = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("rstw_idle_state", state_mon, 4'd0);
        chk("rstw_idle_valid", cmd_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
